// File: rtl/usbf_ep_req_arb.sv
// usbf_ep_req_arb: hclk-domain scheduler issuing one spaced request pulse at a time to the MEM synchronizers.
// Optional: define USBF_REQ_ARB_STAT_EN to add the saturating overrun counter output arb_ovf_cnt_o.
module usbf_ep_req_arb #(
  parameter int EP_NUM     = 4,
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 6,
  parameter int GAP_W      = 4
) (
  input  logic                     hclk_i,
  input  logic                     rstn_i,
  input  logic [EP_NUM-1:0]        ep_data_rd_req_i,
  input  logic [EP_NUM-1:0]        ep_data_wt_req_i,
  input  logic [DATA_W*EP_NUM-1:0] ep_tx_data_i,
  input  logic [EP_NUM-1:0]        ep_rx_flush_i,
  input  logic [EP_NUM-1:0]        ep_tx_flush_i,
  output logic [EP_NUM-1:0]        arb_rd_req_o,
  output logic [EP_NUM-1:0]        arb_wt_req_o,
  output logic [EP_NUM-1:0]        arb_rx_flush_o,
  output logic [EP_NUM-1:0]        arb_tx_flush_o,
  output logic [DATA_W*EP_NUM-1:0] arb_tx_data_o,
  output logic [EP_NUM-1:0]        arb_pending_o,
  output logic                     arb_busy_o
`ifdef USBF_REQ_ARB_STAT_EN
  ,
  output logic [15:0]              arb_ovf_cnt_o
`endif
);

  localparam int NS  = 2 * EP_NUM;
  localparam int SW  = $clog2(NS);
  localparam int EPW = SW - 1;
  localparam logic [1:0] K_WT = 2'd0, K_RD = 2'd1, K_TXF = 2'd2, K_RXF = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_GAP} state_t;

  state_t                   state_q, state_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [SW-1:0]            ptr_q;
  logic [EPW-1:0]           gnt_ep_q;
  logic [1:0]               gnt_kind_q;
  logic [EP_NUM-1:0]        txf_q, rxf_q, wt_q, rd_q;
  logic [EP_NUM-1:0]        txf_d, rxf_d, wt_d, rd_d, hold_ld;
  logic [DATA_W*EP_NUM-1:0] hold_q, data_q;
  logic [EP_NUM-1:0]        p_rd_q, p_wt_q, p_rxf_q, p_txf_q;

  logic [NS-1:0]  fl, dt;
  logic           fl_vld, lo_vld, hi_vld, arb_vld, arb_data, gnt, hit_e;
  logic [SW-1:0]  fl_s, lo_s, hi_s, dt_s, arb_s, ptr_nxt;
  logic [1:0]     arb_kind;
  logic [EPW-1:0] arb_ep;

  // Flush slots: fixed priority, lowest index. Data slots: first set slot at or after ptr_q, else wrap.
  always_comb begin
    fl = '0;
    dt = '0;
    for (int e = 0; e < EP_NUM; e++) begin
      fl[2*e]   = txf_q[e];
      fl[2*e+1] = rxf_q[e];
      dt[2*e]   = wt_q[e];
      dt[2*e+1] = rd_q[e];
    end
    fl_vld = 1'b0; fl_s = '0;
    lo_vld = 1'b0; lo_s = '0;
    hi_vld = 1'b0; hi_s = '0;
    for (int s = NS - 1; s >= 0; s--) begin
      if (fl[s]) begin
        fl_vld = 1'b1;
        fl_s   = SW'(s);
      end
      if (dt[s]) begin
        lo_vld = 1'b1;
        lo_s   = SW'(s);
        if (SW'(s) >= ptr_q) begin
          hi_vld = 1'b1;
          hi_s   = SW'(s);
        end
      end
    end
    dt_s     = hi_vld ? hi_s : lo_s;
    arb_vld  = fl_vld | lo_vld;
    arb_data = ~fl_vld;
    arb_s    = fl_vld ? fl_s : dt_s;
    arb_kind = fl_vld ? (fl_s[0] ? K_RXF : K_TXF) : (dt_s[0] ? K_RD : K_WT);
  end

  assign arb_ep  = arb_s[SW-1:1];
  assign ptr_nxt = (dt_s == SW'(NS - 1)) ? '0 : dt_s + SW'(1);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    gnt     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_vld) begin
          gnt     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: begin
        state_d = S_GAP;
        gap_d   = GAP_W'(GAP_CYCLES - 1);
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // A flush clears the matching data request and wins over a same-cycle request; requests hitting a set bit are dropped.
  always_comb begin
    txf_d   = txf_q;
    rxf_d   = rxf_q;
    wt_d    = wt_q;
    rd_d    = rd_q;
    hold_ld = '0;
    hit_e   = 1'b0;
    for (int e = 0; e < EP_NUM; e++) begin
      hit_e      = gnt && (arb_ep == EPW'(e));
      txf_d[e]   = (txf_q[e] & ~(hit_e && arb_kind == K_TXF)) | (ep_tx_flush_i[e] & ~txf_q[e]);
      rxf_d[e]   = (rxf_q[e] & ~(hit_e && arb_kind == K_RXF)) | (ep_rx_flush_i[e] & ~rxf_q[e]);
      wt_d[e]    = ~ep_tx_flush_i[e] &
                   ((wt_q[e] & ~(hit_e && arb_kind == K_WT)) | (ep_data_wt_req_i[e] & ~wt_q[e]));
      rd_d[e]    = ~ep_rx_flush_i[e] &
                   ((rd_q[e] & ~(hit_e && arb_kind == K_RD)) | (ep_data_rd_req_i[e] & ~rd_q[e]));
      hold_ld[e] = ep_data_wt_req_i[e] & ~ep_tx_flush_i[e] & ~wt_q[e];
    end
  end

  always_ff @(posedge hclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      txf_q      <= '0;
      rxf_q      <= '0;
      wt_q       <= '0;
      rd_q       <= '0;
      hold_q     <= '0;
      data_q     <= '0;
      ptr_q      <= '0;
      gnt_ep_q   <= '0;
      gnt_kind_q <= K_WT;
      p_rd_q     <= '0;
      p_wt_q     <= '0;
      p_rxf_q    <= '0;
      p_txf_q    <= '0;
    end else begin
      txf_q <= txf_d;
      rxf_q <= rxf_d;
      wt_q  <= wt_d;
      rd_q  <= rd_d;
      for (int e = 0; e < EP_NUM; e++) begin
        if (hold_ld[e]) hold_q[e*DATA_W +: DATA_W] <= ep_tx_data_i[e*DATA_W +: DATA_W];
      end
      if (gnt) begin
        gnt_ep_q   <= arb_ep;
        gnt_kind_q <= arb_kind;
        if (arb_data) ptr_q <= ptr_nxt;
      end
      if (state_q == S_LOAD && gnt_kind_q == K_WT) begin
        for (int e = 0; e < EP_NUM; e++) begin
          if (gnt_ep_q == EPW'(e)) data_q[e*DATA_W +: DATA_W] <= hold_q[e*DATA_W +: DATA_W];
        end
      end
      // Pulses are registered so the synchronizers see a glitch-free single-cycle level.
      p_rd_q  <= '0;
      p_wt_q  <= '0;
      p_rxf_q <= '0;
      p_txf_q <= '0;
      if (state_q == S_ISSUE) begin
        for (int e = 0; e < EP_NUM; e++) begin
          if (gnt_ep_q == EPW'(e)) begin
            p_wt_q[e]  <= (gnt_kind_q == K_WT);
            p_rd_q[e]  <= (gnt_kind_q == K_RD);
            p_txf_q[e] <= (gnt_kind_q == K_TXF);
            p_rxf_q[e] <= (gnt_kind_q == K_RXF);
          end
        end
      end
    end
  end

`ifdef USBF_REQ_ARB_STAT_EN
  logic [15:0] ovf_cnt_q;
  logic [16:0] ovf_sum;

  always_comb begin
    ovf_sum = {1'b0, ovf_cnt_q};
    for (int e = 0; e < EP_NUM; e++) begin
      ovf_sum = ovf_sum
              + 17'(ep_tx_flush_i[e] & txf_q[e])
              + 17'(ep_rx_flush_i[e] & rxf_q[e])
              + 17'(ep_data_wt_req_i[e] & ~ep_tx_flush_i[e] & wt_q[e])
              + 17'(ep_data_rd_req_i[e] & ~ep_rx_flush_i[e] & rd_q[e]);
    end
  end

  always_ff @(posedge hclk_i or negedge rstn_i) begin
    if (!rstn_i) ovf_cnt_q <= '0;
    else         ovf_cnt_q <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
  end

  assign arb_ovf_cnt_o = ovf_cnt_q;
`endif

  assign arb_rd_req_o   = p_rd_q;
  assign arb_wt_req_o   = p_wt_q;
  assign arb_rx_flush_o = p_rxf_q;
  assign arb_tx_flush_o = p_txf_q;
  assign arb_tx_data_o  = data_q;
  assign arb_pending_o  = txf_q | rxf_q | wt_q | rd_q;
  assign arb_busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_usbf_ep_req_arb.sv
// Scoreboard bench for usbf_ep_req_arb: directed requests push expected pulses; a monitor pops and compares.
module tb_usbf_ep_req_arb;
  localparam int EP = 4;
  localparam int DW = 32;
  localparam int G  = 6;

  logic            hclk = 1'b0;
  logic            rstn = 1'b0;
  logic [EP-1:0]   rd_req = '0, wt_req = '0, rx_fl = '0, tx_fl = '0;
  logic [DW*EP-1:0] tx_data = '0;

  logic [EP-1:0]    a_rd, a_wt, a_rxf, a_txf, a_pend;
  logic [DW*EP-1:0] a_data;
  logic             a_busy;
`ifdef USBF_REQ_ARB_STAT_EN
  logic [15:0]      a_ovf;
`endif

  usbf_ep_req_arb #(.EP_NUM(EP), .DATA_W(DW), .GAP_CYCLES(G), .GAP_W(4)) dut (
    .hclk_i           (hclk),
    .rstn_i           (rstn),
    .ep_data_rd_req_i (rd_req),
    .ep_data_wt_req_i (wt_req),
    .ep_tx_data_i     (tx_data),
    .ep_rx_flush_i    (rx_fl),
    .ep_tx_flush_i    (tx_fl),
    .arb_rd_req_o     (a_rd),
    .arb_wt_req_o     (a_wt),
    .arb_rx_flush_o   (a_rxf),
    .arb_tx_flush_o   (a_txf),
    .arb_tx_data_o    (a_data),
    .arb_pending_o    (a_pend),
    .arb_busy_o       (a_busy)
`ifdef USBF_REQ_ARB_STAT_EN
    ,
    .arb_ovf_cnt_o    (a_ovf)
`endif
  );

  always #5 hclk = ~hclk;

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  typedef struct {
    logic [EP-1:0]    rd, wt, rxf, txf;
    logic [DW*EP-1:0] data;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  logic [DW*EP-1:0] exp_txdata = '0;
  int               n_vec = 0;
  int               n_err = 0;

  always @(negedge hclk) begin : monitor
    exp_t e;
    if (rstn && ((a_rd | a_wt | a_rxf | a_txf) != '0)) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL pulse_unexpected: got rd=%b wt=%b rxf=%b txf=%b at cycle %0d, required no pulse",
                 a_rd, a_wt, a_rxf, a_txf, cyc);
      end else begin
        e = sb.pop_front();
        if ({a_rd, a_wt, a_rxf, a_txf} !== {e.rd, e.wt, e.rxf, e.txf} || a_data !== e.data || cyc != e.cyc) begin
          n_err++;
          $display("FAIL pulse: got rd=%b wt=%b rxf=%b txf=%b data=%h cyc=%0d, required rd=%b wt=%b rxf=%b txf=%b data=%h cyc=%0d",
                   a_rd, a_wt, a_rxf, a_txf, a_data, cyc, e.rd, e.wt, e.rxf, e.txf, e.data, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [EP-1:0] rd, input logic [EP-1:0] wt, input logic [EP-1:0] rxf,
                      input logic [EP-1:0] txf, input int c);
    exp_t e;
    e.rd = rd; e.wt = wt; e.rxf = rxf; e.txf = txf;
    e.data = exp_txdata;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic clr_in();
    rd_req = '0; wt_req = '0; rx_fl = '0; tx_fl = '0; tx_data = '0;
  endtask

  task automatic do_reset();
    clr_in();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    exp_txdata = '0;
    tick();
  endtask

  task automatic wait_idle(input string nm);
    int i;
    i = 0;
    while ((a_busy || sb.size() != 0) && i < 300) begin
      tick();
      i++;
    end
    chk(nm, 128'(a_busy), 128'(0));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run did not finish, required completion before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    // Reset state
    tick();
    chk("rst_pulses", 128'({a_rd, a_wt, a_rxf, a_txf}), 128'(0));
    chk("rst_pend",   128'(a_pend), 128'(0));
    chk("rst_busy",   128'(a_busy), 128'(0));
    chk("rst_data",   a_data, 128'(0));
`ifdef USBF_REQ_ARB_STAT_EN
    chk("rst_ovf",    128'(a_ovf), 128'(0));
`endif
    rstn = 1'b1;
    tick();

    // 1: single write on EP1
    c = cyc;
    wt_req = 4'b0010;
    tx_data[63:32] = 32'hA5A5_0001;
    exp_txdata[63:32] = 32'hA5A5_0001;
    push(4'b0000, 4'b0010, 4'b0000, 4'b0000, c + 4);
    tick();
    clr_in();
    chk("t1_pend_set", 128'(a_pend), 128'(4'b0010));
    chk("t1_busy_idle", 128'(a_busy), 128'(0));
    tick();
    chk("t1_busy_gnt", 128'(a_busy), 128'(1));
    chk("t1_pend_clr", 128'(a_pend), 128'(0));
    tick();
    chk("t1_data_pre", 128'(a_data[63:32]), 128'(32'hA5A5_0001));
    wait_idle("t1_idle");

    // 2: four simultaneous reads from a fresh pointer
    do_reset();
    c = cyc;
    rd_req = 4'b1111;
    for (int k = 0; k < EP; k++) push(4'(1 << k), 4'b0000, 4'b0000, 4'b0000, c + 4 + k * (G + 3));
    tick();
    clr_in();
    tick_to(c + 4 + 3 * (G + 3) + G - 1);
    chk("t2_busy_last_gap", 128'(a_busy), 128'(1));
    tick();
    chk("t2_busy_done", 128'(a_busy), 128'(0));
    chk("t2_sb_empty", 128'(sb.size()), 128'(0));

    // 3: tx flush cancels a pending write and goes ahead of a read
    c = cyc;
    rd_req = 4'b1000;
    push(4'b1000, 4'b0000, 4'b0000, 4'b0000, c + 4);
    tick();
    clr_in();
    wt_req = 4'b0100;
    tx_data[95:64] = 32'h0000_2222;
    tick();
    clr_in();
    tx_fl = 4'b0100;
    rd_req = 4'b0001;
    push(4'b0000, 4'b0000, 4'b0000, 4'b0100, c + 4 + (G + 3));
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000, c + 4 + 2 * (G + 3));
    tick();
    clr_in();
    chk("t3_pend", 128'(a_pend), 128'(4'b0101));
    wait_idle("t3_idle");
    chk("t3_data_kept", a_data, exp_txdata);

    // 4: write overrun on EP0 while busy on EP1
    c = cyc;
    rd_req = 4'b0010;
    push(4'b0010, 4'b0000, 4'b0000, 4'b0000, c + 4);
    tick();
    clr_in();
    wt_req = 4'b0001;
    tx_data[31:0] = 32'h0000_0001;
    tick();
    clr_in();
    wt_req = 4'b0001;
    tx_data[31:0] = 32'h0000_0002;
    exp_txdata[31:0] = 32'h0000_0001;
    push(4'b0000, 4'b0001, 4'b0000, 4'b0000, c + 4 + (G + 3));
    tick();
    clr_in();
    chk("t4_pend", 128'(a_pend), 128'(4'b0001));
`ifdef USBF_REQ_ARB_STAT_EN
    chk("t4_ovf", 128'(a_ovf), 128'(1));
`endif
    wait_idle("t4_idle");
    chk("t4_data", 128'(a_data[31:0]), 128'(32'h0000_0001));

    // 5: reset asserted around the pulse
    c = cyc;
    rd_req = 4'b0100;
    tick();
    clr_in();
    wt_req = 4'b1000;
    tx_data[127:96] = 32'h0000_3333;
    tick();
    clr_in();
    tick_to(c + 4);
    chk("t5_pulse_hi", 128'(a_rd), 128'(4'b0100));
    rstn = 1'b0;
    #1;
    chk("t5_pulses_rst", 128'({a_rd, a_wt, a_rxf, a_txf}), 128'(0));
    chk("t5_pend_rst", 128'(a_pend), 128'(0));
    chk("t5_busy_rst", 128'(a_busy), 128'(0));
    chk("t5_data_rst", a_data, 128'(0));
    tick();
    tick();
    rstn = 1'b1;
    exp_txdata = '0;
    repeat (25) tick();
    chk("t5_no_busy", 128'(a_busy), 128'(0));
    chk("final_sb_empty", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
